alu_exec: RTL
=============

// Module: alu_exec
// PURPOSE
//  Consumer end of if_instr_alu: executes one decoded ALU instruction, %s <- %b op (%a | a_imm).
//  Reads operands from the register file through its single synchronous read port, computes, then
//  writes the result and updates the condition flags. Sits between decode and the register file.
// PARAMETERS
//  W    pkg_reg::REG_WIDTH  operand/result width (64)
//  AW   pkg_reg::REG_ADDRW  register address width (4)
// PORTS
//  clk         in   1    single clock, all state on posedge
//  rst         in   1    synchronous, active-high reset
//  in_valid    in   1    instr fields valid
//  in_ready    out  1    block can accept; 1 only in IDLE
//  instr       if   -    if_instr_alu, read-only use: op, a_sel, s_reg, b_reg, a_reg, a_imm
//  rf_rd_addr  out  AW   register file read address
//  rf_rd_data  in   W    R[rf_rd_addr of previous cycle] (1-cycle read latency)
//  rf_wr_en    out  1    write strobe
//  rf_wr_addr  out  AW   write address (= s_reg)
//  rf_wr_data  out  W    result
//  flags       out  4    {OF,CF,SF,ZF}, registered
//  done        out  1    1-cycle pulse, coincident with rf_wr_en
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; rf_wr_en=0; done=0; flags=0; rf_rd_addr=0; datapath regs=0.
//  Accept: in_valid&&in_ready in IDLE latches op, a_sel, s_reg, b_reg, a_reg, a_imm; instr ignored
//   afterwards. in_ready=0 in every non-IDLE state.
//  FSM: IDLE -> RD_B -> (a_sel==ALU_REG ? RD_A : EXEC) -> EXEC -> WB -> IDLE.
//   RD_B: rf_rd_addr=b_reg.  RD_A: rf_rd_addr=a_reg; b_q <= rf_rd_data.
//   EXEC: operand b = (path via RD_A ? b_q : rf_rd_data); a = (ALU_REG ? rf_rd_data : a_imm);
//         res_q/flags_n <= alu_core(op,b,a).
//   WB: rf_wr_en=1, rf_wr_addr=s_reg, rf_wr_data=res_q, done=1, flags <= flags_n.
//  Latency accept->WB: 3 cycles (ALU_IMM), 4 cycles (ALU_REG). Earliest next accept: cycle after WB.
//  Ops (result modulo 2^W; operands ordered b op a):
//   ADD b+a: CF=carry out, OF=signed overflow.  SUB b-a: CF=borrow (b<a unsigned), OF=signed ovf.
//   AND/OR/XOR: bitwise, CF=OF=0.  MUL: low W bits of product, CF=OF=0.
//   SHL/SHR/SAR: shift b by a[$clog2(W)-1:0]; upper bits of a ignored; CF=OF=0.
//   All ops: ZF=(res==0), SF=res[W-1]. Unknown op encoding: result 0, flags ZF=1 others 0.
//  Register %0: block writes unconditionally; zero-register semantics live in the register file.
//  s_reg equal to b_reg/a_reg: operands already captured before WB, no hazard inside the block.
//  flags hold their value between WBs; only WB updates them.
//  rst mid-instruction: back to IDLE next cycle, no write, no done, flags cleared.
//  in_valid while busy: ignored, not buffered; producer must hold it until in_ready.
// STRUCTURE
//  pkg_alu: op_t members ADD,SUB,AND,OR,XOR,MUL,SHL,SHR,SAR; sel_t ALU_REG/ALU_IMM; flag bit indices.
//  pkg_alu: state_t {IDLE,RD_B,RD_A,EXEC,WB}. pkg_reg: REG_WIDTH, REG_ADDRW.
//  Sub-module alu_core: purely combinational (op,b,a) -> (res,flags). alu_exec owns FSM and regs.
// TESTING (W=64)
//  ADD imm: R2=5, op=ADD a_sel=IMM a_imm=7 b=%2 s=%3 -> WB 3 cycles after accept, R3=12, flags=0000.
//  SUB reg borrow: R1=1, R2=2, SUB b=%1 a=%2 s=%4 -> 4 cycles, R4=0xFFFF_FFFF_FFFF_FFFF, CF=1 SF=1 ZF=0 OF=0.
//  Overflow: R1=0x7FFF_FFFF_FFFF_FFFF, ADD a_imm=1 -> res=0x8000_0000_0000_0000, OF=1 SF=1 CF=0.
//  Shifts: R1=0x8000_0000_0000_0000, SAR a_imm=0x43 -> shift 3, res=0xF000_0000_0000_0000; SHR same -> 0x1000_0000_0000_0000.
//  Handshake: in_valid held high across 3 back-to-back instrs -> in_ready only in IDLE, each accepted once, one done each.
//  Reset mid-op: assert rst in EXEC -> no rf_wr_en/done, flags=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the ALU execute slice.
// Purpose: register-file geometry, opcode/operand-select/FSM encodings, flag bit positions.
// Ports: none (package).
package alu_exec_pkg;

  localparam int REG_WIDTH = 64;
  localparam int REG_ADDRW = 4;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    MUL = 4'd5,
    SHL = 4'd6,
    SHR = 4'd7,
    SAR = 4'd8
  } op_t;

  typedef enum logic {
    ALU_REG = 1'b0,
    ALU_IMM = 1'b1
  } sel_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_B = 3'd1,
    RD_A = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;

  // Bit positions inside the 4-bit {OF,CF,SF,ZF} flag word.
  localparam int FLAG_ZF = 0;
  localparam int FLAG_SF = 1;
  localparam int FLAG_CF = 2;
  localparam int FLAG_OF = 3;

endpackage

// File: rtl/alu_exec_if.sv
// Decoded ALU instruction handshake from decode to the execute block.
// Ports: in_valid/in_ready handshake plus op, a_sel, s_reg, b_reg, a_reg, a_imm fields.
// Producer must hold in_valid and the fields stable until in_ready is seen.
interface alu_exec_if;
  import alu_exec_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  op_t                  op;
  sel_t                 a_sel;
  logic [REG_ADDRW-1:0] s_reg;
  logic [REG_ADDRW-1:0] b_reg;
  logic [REG_ADDRW-1:0] a_reg;
  logic [REG_WIDTH-1:0] a_imm;

  modport master (
    output in_valid, op, a_sel, s_reg, b_reg, a_reg, a_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, op, a_sel, s_reg, b_reg, a_reg, a_imm,
    output in_ready
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: res = b op a, plus {OF,CF,SF,ZF}.
// Ports: op, b, a in; res, flags out. Latency 0, no handshake.
// Unknown opcodes yield res=0, which makes ZF the only flag set.
module alu_core
  import alu_exec_pkg::*;
#(
  parameter int W = REG_WIDTH
) (
  input  op_t          op,
  input  logic [W-1:0] b,
  input  logic [W-1:0] a,
  output logic [W-1:0] res,
  output logic [3:0]   flags
);

  localparam int SHW = $clog2(W);

  logic [SHW-1:0] shamt;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic           cf;
  logic           of;

  // Shift distance uses only the low log2(W) bits of a.
  assign shamt = a[SHW-1:0];

  always_comb begin
    res   = '0;
    cf    = 1'b0;
    of    = 1'b0;
    flags = '0;
    sum   = {1'b0, b} + {1'b0, a};
    // Top bit of the widened difference is the unsigned borrow (b < a).
    diff  = {1'b0, b} - {1'b0, a};
    case (op)
      ADD: begin
        res = sum[W-1:0];
        cf  = sum[W];
        of  = (b[W-1] == a[W-1]) && (sum[W-1] != b[W-1]);
      end
      SUB: begin
        res = diff[W-1:0];
        cf  = diff[W];
        of  = (b[W-1] != a[W-1]) && (diff[W-1] != b[W-1]);
      end
      AND:     res = b & a;
      OR:      res = b | a;
      XOR:     res = b ^ a;
      MUL:     res = b * a;
      SHL:     res = b << shamt;
      SHR:     res = b >> shamt;
      SAR:     res = $signed(b) >>> shamt;
      default: res = '0;
    endcase
    flags[FLAG_ZF] = (res == '0);
    flags[FLAG_SF] = res[W-1];
    flags[FLAG_CF] = cf;
    flags[FLAG_OF] = of;
  end

endmodule

// File: rtl/alu_exec.sv
// Executes one decoded ALU instruction: reads operands via the RF sync read port, computes, writes back.
// Ports: clk, rst (sync, active-high), instr (slave handshake), rf_rd_*, rf_wr_*, flags, done.
// Latency accept->WB 3 cycles (immediate) / 4 (register); in_ready only in IDLE, busy input ignored.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int W  = REG_WIDTH,
  parameter int AW = REG_ADDRW
) (
  input  logic          clk,
  input  logic          rst,
  alu_exec_if.slave     instr,
  output logic [AW-1:0] rf_rd_addr,
  input  logic [W-1:0]  rf_rd_data,
  output logic          rf_wr_en,
  output logic [AW-1:0] rf_wr_addr,
  output logic [W-1:0]  rf_wr_data,
  output logic [3:0]    flags,
  output logic          done
);

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  sel_t          sel_q, sel_d;
  logic [AW-1:0] s_q, s_d;
  logic [AW-1:0] b_addr_q, b_addr_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [W-1:0]  imm_q, imm_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [3:0]    flags_n_q, flags_n_d;
  logic [3:0]    flags_q, flags_d;

  logic [W-1:0]  opnd_b;
  logic [W-1:0]  opnd_a;
  logic [W-1:0]  core_res;
  logic [3:0]    core_flags;

  // In EXEC the read port carries the last address issued: a_reg on the
  // register path (b was parked in b_q during RD_A), b_reg on the immediate path.
  assign opnd_b = (sel_q == ALU_REG) ? b_q        : rf_rd_data;
  assign opnd_a = (sel_q == ALU_REG) ? rf_rd_data : imm_q;

  alu_core #(.W(W)) u_core (
    .op    (op_q),
    .b     (opnd_b),
    .a     (opnd_a),
    .res   (core_res),
    .flags (core_flags)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sel_d     = sel_q;
    s_d       = s_q;
    b_addr_d  = b_addr_q;
    a_addr_d  = a_addr_q;
    imm_d     = imm_q;
    b_d       = b_q;
    res_d     = res_q;
    flags_n_d = flags_n_q;
    flags_d   = flags_q;
    unique case (state_q)
      IDLE: begin
        if (instr.in_valid) begin
          op_d     = instr.op;
          sel_d    = instr.a_sel;
          s_d      = instr.s_reg;
          b_addr_d = instr.b_reg;
          a_addr_d = instr.a_reg;
          imm_d    = instr.a_imm;
          state_d  = RD_B;
        end
      end
      RD_B: state_d = (sel_q == ALU_REG) ? RD_A : EXEC;
      RD_A: begin
        b_d     = rf_rd_data;
        state_d = EXEC;
      end
      EXEC: begin
        res_d     = core_res;
        flags_n_d = core_flags;
        state_d   = WB;
      end
      WB: begin
        flags_d = flags_n_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= ADD;
      sel_q     <= ALU_REG;
      s_q       <= '0;
      b_addr_q  <= '0;
      a_addr_q  <= '0;
      imm_q     <= '0;
      b_q       <= '0;
      res_q     <= '0;
      flags_n_q <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sel_q     <= sel_d;
      s_q       <= s_d;
      b_addr_q  <= b_addr_d;
      a_addr_q  <= a_addr_d;
      imm_q     <= imm_d;
      b_q       <= b_d;
      res_q     <= res_d;
      flags_n_q <= flags_n_d;
      flags_q   <= flags_d;
    end
  end

  assign instr.in_ready = (state_q == IDLE);
  assign rf_rd_addr     = (state_q == RD_B) ? b_addr_q :
                          (state_q == RD_A) ? a_addr_q : '0;
  assign rf_wr_en       = (state_q == WB);
  assign done           = (state_q == WB);
  assign rf_wr_addr     = s_q;
  assign rf_wr_data     = res_q;
  assign flags          = flags_q;

endmodule
